// File: rtl/tl_timer_pkg.sv
// Register map, field indices and register-file type for tl_timer.
package tl_timer_pkg;

  localparam logic [4:0] TIMER_CTRL        = 5'h00;
  localparam logic [4:0] TIMER_PRESCALE    = 5'h04;
  localparam logic [4:0] TIMER_MTIME_LO    = 5'h08;
  localparam logic [4:0] TIMER_MTIME_HI    = 5'h0C;
  localparam logic [4:0] TIMER_MTIMECMP_LO = 5'h10;
  localparam logic [4:0] TIMER_MTIMECMP_HI = 5'h14;
  localparam logic [4:0] TIMER_INTR_STATE  = 5'h18;
  localparam logic [4:0] TIMER_UNMAPPED    = 5'h1C;

  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_IE = 1;

  typedef enum logic {
    RESP_IDLE,
    RESP_PEND
  } resp_state_e;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [31:0] prescale;
    logic [63:0] mtimecmp;
  } timer_reg_t;

  function automatic logic [31:0] apply_mask(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Shared TL-UL bus types used by crossbar devices.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tl_timer_core.sv
// Prescaler, 64-bit mtime counter, compare and sticky INTR_STATE.
module tl_timer_core
  import tl_timer_pkg::*;
#(
  parameter int unsigned PrescaleW = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en,
  input  logic [PrescaleW-1:0] prescale,
  input  logic                 prescale_we,
  input  logic                 mtime_lo_we,
  input  logic                 mtime_hi_we,
  input  logic [31:0]          wdata,
  input  logic [63:0]          mtimecmp,
  input  logic                 intr_clr,
  output logic [63:0]          mtime,
  output logic                 intr_state
);

  logic [PrescaleW-1:0] pcnt;
  logic                 tick;
  logic                 cmp_hit;
  logic [63:0]          mtime_nxt;

  assign tick    = en && (pcnt == prescale);
  assign cmp_hit = en && (mtime >= mtimecmp);

  // A bus write to either half swallows a coincident tick, including its carry.
  always_comb begin
    mtime_nxt = mtime;
    if (mtime_lo_we) begin
      mtime_nxt[31:0] = wdata;
    end else if (mtime_hi_we) begin
      mtime_nxt[63:32] = wdata;
    end else if (tick) begin
      mtime_nxt = mtime + 64'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt <= '0;
    end else if (prescale_we || tick) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime      <= '0;
      intr_state <= 1'b0;
    end else begin
      mtime <= mtime_nxt;
      if (cmp_hit) begin
        intr_state <= 1'b1;
      end else if (intr_clr) begin
        intr_state <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tl_timer.sv
// TL-UL timer device: request decode, register file and registered response.
module tl_timer
  import tlul_pkg::*;
  import tl_timer_pkg::*;
#(
  parameter int unsigned PrescaleW = 12
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o,
  output logic    intr_timer_o
);

  localparam logic [31:0] PrescaleMask = 32'((64'd1 << PrescaleW) - 64'd1);

  resp_state_e state_q, state_d;
  timer_reg_t  reg_q;

  logic        accept;
  logic        op_get;
  logic        op_put;
  logic        req_err;
  logic        wr_en;
  logic [4:0]  reg_addr;
  logic [31:0] rdata;
  logic [31:0] wdata_merged;
  logic [63:0] mtime;
  logic        intr_state;

  tl_d_op_e    d_opcode_q;
  logic [1:0]  d_size_q;
  logic [7:0]  d_source_q;
  logic [31:0] d_data_q;
  logic        d_error_q;

  logic        unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:5]};

  assign accept   = tl_i.a_valid && (state_q == RESP_IDLE);
  assign reg_addr = {tl_i.a_address[4:2], 2'b00};
  assign op_get   = (tl_i.a_opcode == Get);
  assign op_put   = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
  assign req_err  = (|tl_i.a_address[1:0]) || (reg_addr == TIMER_UNMAPPED) || !(op_get || op_put);
  assign wr_en    = accept && op_put && !req_err;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESP_IDLE: if (accept)       state_d = RESP_PEND;
      RESP_PEND: if (tl_i.d_ready) state_d = RESP_IDLE;
      default:                     state_d = RESP_IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (reg_addr)
      TIMER_CTRL:        rdata = {30'b0, reg_q.ctrl};
      TIMER_PRESCALE:    rdata = reg_q.prescale;
      TIMER_MTIME_LO:    rdata = mtime[31:0];
      TIMER_MTIME_HI:    rdata = mtime[63:32];
      TIMER_MTIMECMP_LO: rdata = reg_q.mtimecmp[31:0];
      TIMER_MTIMECMP_HI: rdata = reg_q.mtimecmp[63:32];
      TIMER_INTR_STATE:  rdata = {31'b0, intr_state};
      default:           rdata = '0;
    endcase
  end

  // The read mux doubles as the old value for byte-masked merges.
  assign wdata_merged = apply_mask(rdata, tl_i.a_data, tl_i.a_mask);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q.ctrl     <= '0;
      reg_q.prescale <= '0;
      reg_q.mtimecmp <= '1;
    end else if (wr_en) begin
      case (reg_addr)
        TIMER_CTRL:        reg_q.ctrl              <= wdata_merged[1:0];
        TIMER_PRESCALE:    reg_q.prescale          <= wdata_merged & PrescaleMask;
        TIMER_MTIMECMP_LO: reg_q.mtimecmp[31:0]    <= wdata_merged;
        TIMER_MTIMECMP_HI: reg_q.mtimecmp[63:32]   <= wdata_merged;
        default: ;
      endcase
    end
  end

  tl_timer_core #(
    .PrescaleW(PrescaleW)
  ) u_core (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en          (reg_q.ctrl[CTRL_EN]),
    .prescale    (reg_q.prescale[PrescaleW-1:0]),
    .prescale_we (wr_en && (reg_addr == TIMER_PRESCALE)),
    .mtime_lo_we (wr_en && (reg_addr == TIMER_MTIME_LO)),
    .mtime_hi_we (wr_en && (reg_addr == TIMER_MTIME_HI)),
    .wdata       (wdata_merged),
    .mtimecmp    (reg_q.mtimecmp),
    .intr_clr    (wr_en && (reg_addr == TIMER_INTR_STATE) && tl_i.a_mask[0] && tl_i.a_data[0]),
    .mtime       (mtime),
    .intr_state  (intr_state)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RESP_IDLE;
      d_opcode_q <= AccessAck;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        d_opcode_q <= op_get ? AccessAckData : AccessAck;
        d_size_q   <= tl_i.a_size;
        d_source_q <= tl_i.a_source;
        d_data_q   <= (op_get && !req_err) ? rdata : '0;
        d_error_q  <= req_err;
      end
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = (state_q == RESP_PEND);
    tl_o.d_opcode = d_opcode_q;
    tl_o.d_size   = d_size_q;
    tl_o.d_source = d_source_q;
    tl_o.d_data   = d_data_q;
    tl_o.d_error  = d_error_q;
    tl_o.a_ready  = (state_q == RESP_IDLE);
  end

  assign intr_timer_o = intr_state & reg_q.ctrl[CTRL_IE];

endmodule

// File: tb/tb_tl_timer.sv
// Directed bench for tl_timer with a cycle-level reference model and per-cycle compare.
module tb_tl_timer;
  import tlul_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n;
  tl_h2d_t tl_i;
  tl_d2h_t tl_o;
  logic    intr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [7:0] src_ctr = 8'h01;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tl_timer #(.PrescaleW(12)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tl_i         (tl_i),
    .tl_o         (tl_o),
    .intr_timer_o (intr)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: registers as plain words, mtime as one 64-bit number.
  logic        m_pending = 1'b0;
  logic [31:0] m_ctrl = '0, m_pre = '0, m_cmp_lo = '1, m_cmp_hi = '1;
  logic [63:0] m_mtime = '0;
  int unsigned m_pcnt = 0;
  logic        m_intr = 1'b0;
  logic [2:0]  e_op = '0;
  logic [1:0]  e_size = '0;
  logic [7:0]  e_src = '0;
  logic [31:0] e_data = '0;
  logic        e_err = 1'b0;

  function automatic logic [31:0] mreg(input int idx);
    case (idx)
      0: return m_ctrl;
      1: return m_pre;
      2: return m_mtime[31:0];
      3: return m_mtime[63:32];
      4: return m_cmp_lo;
      5: return m_cmp_hi;
      6: return {31'b0, m_intr};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
    return {m[3] ? d[31:24] : o[31:24], m[2] ? d[23:16] : o[23:16],
            m[1] ? d[15:8]  : o[15:8],  m[0] ? d[7:0]   : o[7:0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic tick, hit, acc, get, bad, wr;
    int idx;
    logic [31:0] wv;
    logic [63:0] nm;
    if (!rst_n) begin
      m_pending = 1'b0; m_ctrl = '0; m_pre = '0; m_cmp_lo = '1; m_cmp_hi = '1;
      m_mtime = '0; m_pcnt = 0; m_intr = 1'b0;
    end else begin
      tick = m_ctrl[0] && (m_pcnt == m_pre);
      hit  = m_ctrl[0] && (m_mtime >= {m_cmp_hi, m_cmp_lo});
      acc  = tl_i.a_valid && !m_pending;
      idx  = int'(tl_i.a_address[4:2]);
      get  = (tl_i.a_opcode == Get);
      bad  = (tl_i.a_address[1:0] != 2'b00) || (idx == 7) ||
             !(get || tl_i.a_opcode == PutFullData || tl_i.a_opcode == PutPartialData);
      wr   = acc && !get && !bad;
      wv   = merge(mreg(idx), tl_i.a_data, tl_i.a_mask);
      if (m_pending && tl_i.d_ready) m_pending = 1'b0;
      if (acc) begin
        m_pending = 1'b1;
        e_op   = get ? 3'd1 : 3'd0;
        e_size = tl_i.a_size;
        e_src  = tl_i.a_source;
        e_data = (get && !bad) ? mreg(idx) : 32'h0;
        e_err  = bad;
      end
      nm = m_mtime + (tick ? 64'd1 : 64'd0);
      if (wr && idx == 2) nm = {m_mtime[63:32], wv};
      if (wr && idx == 3) nm = {wv, m_mtime[31:0]};
      if (wr && idx == 1) m_pcnt = 0;
      else if (m_ctrl[0]) m_pcnt = tick ? 0 : m_pcnt + 1;
      if (hit) m_intr = 1'b1;
      else if (wr && idx == 6 && tl_i.a_mask[0] && tl_i.a_data[0]) m_intr = 1'b0;
      m_mtime = nm;
      if (wr && idx == 0) m_ctrl = wv & 32'h3;
      if (wr && idx == 1) m_pre = wv & 32'hFFF;
      if (wr && idx == 4) m_cmp_lo = wv;
      if (wr && idx == 5) m_cmp_hi = wv;
    end
  end

  always @(negedge clk) begin
    check("a_ready", tl_o.a_ready, !m_pending);
    check("d_valid", tl_o.d_valid, m_pending);
    if (m_pending)
      check("d_chan", {tl_o.d_opcode, tl_o.d_param, tl_o.d_size, tl_o.d_source, tl_o.d_data, tl_o.d_error},
            {e_op, 3'b000, e_size, e_src, e_data, e_err});
    check("intr", intr, m_intr && m_ctrl[1]);
  end

  task automatic xact(input tl_a_op_e op, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] data, output logic [31:0] rd, output logic er);
    int n;
    @(posedge clk); #1;
    tl_i.a_valid = 1'b1; tl_i.a_opcode = op; tl_i.a_address = addr;
    tl_i.a_mask = mask; tl_i.a_data = data; tl_i.a_size = 2'd2; tl_i.a_source = src_ctr;
    src_ctr++;
    n = 0;
    @(negedge clk);
    while (!tl_o.a_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_wait", tl_o.a_ready, 1'b1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    tl_i.a_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!tl_o.d_valid && n < 50) begin @(negedge clk); n++; end
    check("resp_wait", tl_o.d_valid, 1'b1);
    rd = tl_o.d_data;
    er = tl_o.d_error;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd; logic er;
    xact(PutFullData, addr, 4'hF, data, rd, er);
  endtask

  task automatic rdreg(input logic [31:0] addr, output logic [31:0] rd);
    logic er;
    xact(Get, addr, 4'hF, 32'h0, rd, er);
  endtask

  logic [31:0] rst_exp [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};

  initial begin : stim
    logic [31:0] rd;
    logic er;
    int rise;
    tl_i = '0;
    tl_i.d_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      xact(Get, 32'(i * 4), 4'hF, 32'h0, rd, er);
      check($sformatf("rst_reg_%0d", i), rd, rst_exp[i]);
      check($sformatf("rst_err_%0d", i), er, 1'b0);
    end
    xact(Get, 32'h1C, 4'hF, 32'h0, rd, er);
    check("unmapped_err", er, 1'b1);
    check("unmapped_data", rd, 32'h0);
    check("rst_intr", intr, 1'b0);

    wr(32'h04, 32'd3);
    wr(32'h00, 32'h1);
    repeat (40) @(posedge clk);
    rdreg(32'h08, rd);
    check("prescale3_mtime_10pm1", (rd >= 32'd9) && (rd <= 32'd11), 1'b1);

    wr(32'h00, 32'h0);
    wr(32'h04, 32'h0);
    wr(32'h08, 32'hFFFF_FFFE);
    wr(32'h0C, 32'h0);
    wr(32'h00, 32'h1);
    wr(32'h00, 32'h0);
    rdreg(32'h0C, rd);
    check("carry_hi", rd, 32'h1);
    rdreg(32'h08, rd);
    check("carry_lo", rd, 32'h0);

    wr(32'h08, 32'h0);
    wr(32'h0C, 32'h0);
    wr(32'h10, 32'd20);
    wr(32'h14, 32'h0);
    wr(32'h00, 32'h3);
    rise = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (intr) begin rise = cyc; break; end
    end
    check("intr_rise_cycle", 64'(rise), 64'(acc_cyc + 21));
    wr(32'h18, 32'h1);
    rdreg(32'h18, rd);
    check("w1c_reset_by_cmp", rd, 32'h1);
    check("w1c_intr_held", intr, 1'b1);
    wr(32'h14, 32'hFFFF_FFFF);
    wr(32'h10, 32'hFFFF_FFFF);
    wr(32'h18, 32'h1);
    rdreg(32'h18, rd);
    check("w1c_cleared", rd, 32'h0);
    check("w1c_intr_low", intr, 1'b0);

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    xact(PutPartialData, 32'h10, 4'b0010, 32'h0000_AB00, rd, er);
    rdreg(32'h10, rd);
    check("partial_cmp_lo", rd, 32'hFFFF_ABFF);

    @(posedge clk); #1;
    tl_i.d_ready = 1'b0;
    tl_i.a_valid = 1'b1; tl_i.a_opcode = Get; tl_i.a_address = 32'h10;
    tl_i.a_mask = 4'hF; tl_i.a_size = 2'd2; tl_i.a_source = 8'h55;
    @(negedge clk);
    check("stall_pre_ready", tl_o.a_ready, 1'b1);
    @(posedge clk); #1;
    tl_i.a_address = 32'h14; tl_i.a_source = 8'h66;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_d_valid", tl_o.d_valid, 1'b1);
      check("stall_d_data", tl_o.d_data, 32'hFFFF_ABFF);
      check("stall_a_ready", tl_o.a_ready, 1'b0);
    end
    @(posedge clk); #1;
    tl_i.d_ready = 1'b1;
    @(negedge clk);
    check("stall_last_valid", tl_o.d_valid, 1'b1);
    @(negedge clk);
    check("after_hs_valid", tl_o.d_valid, 1'b0);
    check("after_hs_ready", tl_o.a_ready, 1'b1);
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    @(negedge clk);
    check("second_valid", tl_o.d_valid, 1'b1);
    check("second_data", tl_o.d_data, 32'hFFFF_FFFF);
    check("second_source", tl_o.d_source, 8'h66);

    xact(Get, 32'h02, 4'hF, 32'h0, rd, er);
    check("misaligned_err", er, 1'b1);
    xact(tl_a_op_e'(3'h2), 32'h00, 4'hF, 32'h3, rd, er);
    check("bad_opcode_err", er, 1'b1);
    rdreg(32'h00, rd);
    check("bad_opcode_noeffect", rd, 32'h0);
    xact(PutFullData, 32'h1C, 4'hF, 32'h1, rd, er);
    check("unmapped_put_err", er, 1'b1);

    wr(32'h14, 32'h0);
    wr(32'h10, 32'h0);
    wr(32'h00, 32'h3);
    repeat (3) @(negedge clk);
    check("pre_reset_intr", intr, 1'b1);
    @(posedge clk); #1;
    tl_i.d_ready = 1'b0;
    tl_i.a_valid = 1'b1; tl_i.a_opcode = Get; tl_i.a_address = 32'h08; tl_i.a_source = 8'h77;
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    @(negedge clk);
    check("pending_before_reset", tl_o.d_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_drop_valid", tl_o.d_valid, 1'b0);
    check("reset_a_ready", tl_o.a_ready, 1'b1);
    check("reset_intr", intr, 1'b0);
    tl_i.d_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
